// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered 8N1 UART transmitter with its own baud counter.
// Optional macro UART_TX_PARITY_EN adds a parity bit and the tx_parity_odd input.
//
// Ports:
//   clk, rst_n     system clock, async active-low reset
//   tx_start       push strobe, one byte of tx_data per high cycle
//   tx_data        byte to push
//   tx_enable      allows new frames to start
//   tx_parity_odd  (UART_TX_PARITY_EN only) odd parity select, sampled at pop
//   txd            serial line, idle high, registered
//   tx_busy        FSM not idle
//   tx_done        one-cycle pulse at end of each stop bit
//   fifo_full      FIFO holds FIFO_DEPTH entries
//   fifo_empty     FIFO holds no entries
//   tx_overflow    one-cycle pulse when a push is dropped
module uart_tx_engine #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_enable,
`ifdef UART_TX_PARITY_EN
  input  logic       tx_parity_odd,
`endif
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       tx_overflow
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [7:0]      head;
  logic            baud_last;
  logic            pop;
  logic            push_ok;

  assign head      = mem[rd_ptr];
  assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));
  assign tx_busy   = (state != IDLE);

  // A frame may start from IDLE, or straight out of the last stop-bit
  // cycle so consecutive frames have no idle gap.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && tx_enable) begin
      pop = (state == IDLE) || ((state == STOP) && baud_last);
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot this cycle.
  assign push_ok   = tx_start && (!fifo_full || pop);
  assign count_nxt = count + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_full   <= 1'b0;
      fifo_empty  <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count       <= count_nxt;
      fifo_full   <= (count_nxt == CW'(FIFO_DEPTH));
      fifo_empty  <= (count_nxt == '0);
      tx_overflow <= tx_start && fifo_full && !pop;
    end
  end

  // txd is loaded from the current state, so the line lags the state
  // by one cycle; every bit is still exactly CLKS_PER_BIT wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            par   <= (^head) ^ tx_parity_odd;
`endif
            baud  <= '0;
            state <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (baud_last) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          txd <= shift[0];
          if (baud_last) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd <= par;
          if (baud_last) begin
            baud  <= '0;
            state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
`endif
        STOP: begin
          txd <= 1'b1;
          if (baud_last) begin
            tx_done <= 1'b1;
            baud    <= '0;
            if (pop) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              par   <= (^head) ^ tx_parity_odd;
`endif
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed + random byte streams, line decoded by a
// sampling UART receiver model and compared with the bytes pushed.
module tb_uart_tx_engine;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_enable;
`ifdef UART_TX_PARITY_EN
  logic       tx_parity_odd;
`endif
  logic       txd;
  logic       tx_busy;
  logic       tx_done;
  logic       fifo_full;
  logic       fifo_empty;
  logic       tx_overflow;

  uart_tx_engine #(
    .CLOCK_RATE(160),
    .BAUD_RATE (10),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
`ifdef UART_TX_PARITY_EN
    .tx_parity_odd(tx_parity_odd),
`endif
    .txd        (txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit line[$];
  int done_q[$];
  int ovf_q[$];

  always @(posedge clk) begin
    #2;
    if (tx_done === 1'b1) done_q.push_back(line.size());
    if (tx_overflow === 1'b1) ovf_q.push_back(line.size());
    line.push_back(txd);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] dec_b[$];
  int         dec_s[$];
  bit         dec_p[$];
  int         dec_err;

  // Receiver model: find a low level, sample each bit at its centre and
  // require all CPB samples of each bit to agree.
  task automatic decode(input int from);
    int i;
    logic [7:0] b;
    bit v;
    dec_b.delete();
    dec_s.delete();
    dec_p.delete();
    dec_err = 0;
    b = '0;
    i = from;
    while (i + FB * CPB <= line.size()) begin
      if (line[i] == 1'b0) begin
        for (int k = 0; k < FB; k++) begin
          v = line[i + k * CPB + CPB / 2];
          for (int c = 0; c < CPB; c++)
            if (line[i + k * CPB + c] != v) dec_err++;
          if (k >= 1 && k <= 8) b[k-1] = v;
        end
        if (line[i + (FB - 1) * CPB + CPB / 2] != 1'b1) dec_err++;
        if (FB == 11) dec_p.push_back(line[i + 9 * CPB + CPB / 2]);
        dec_b.push_back(b);
        dec_s.push_back(i);
        i += FB * CPB;
      end else begin
        i++;
      end
    end
  endtask

  function automatic int cnt_from(input int q[$], input int from);
    int n = 0;
    foreach (q[j]) if (q[j] >= from) n++;
    return n;
  endfunction

  function automatic int zeros_from(input int from);
    int n = 0;
    for (int j = from; j < line.size(); j++) if (line[j] == 1'b0) n++;
    return n;
  endfunction

  function automatic int first_from(input int q[$], input int from);
    foreach (q[j]) if (q[j] >= from) return q[j];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    tx_start = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((fifo_empty !== 1'b1 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tick(4);
    chk({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  logic [7:0] exp_q[$];
  int         L;
  int         L2;
  int         s;
  int         n;
  int         nb;
  logic [7:0] r;

  initial begin
    rst_n     = 1'b0;
    tx_start  = 1'b0;
    tx_data   = '0;
    tx_enable = 1'b1;
`ifdef UART_TX_PARITY_EN
    tx_parity_odd = 1'b0;
`endif
    tick(3);
    chk("rst_txd",   32'(txd),         32'd1);
    chk("rst_busy",  32'(tx_busy),     32'd0);
    chk("rst_empty", 32'(fifo_empty),  32'd1);
    chk("rst_full",  32'(fifo_full),   32'd0);
    chk("rst_done",  32'(tx_done),     32'd0);
    chk("rst_ovf",   32'(tx_overflow), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single byte: latency, bit pattern, done position
    L = line.size();
    push(8'hA5);
    wait_idle("a5", 400);
    decode(L);
    chk("a5_frames", 32'(dec_b.size()), 32'd1);
    if (dec_b.size() >= 1) begin
      chk("a5_byte",  32'(dec_b[0]), 32'hA5);
      chk("a5_start", 32'(dec_s[0]), 32'(L + 2));
      chk("a5_done_at", 32'(first_from(done_q, L)),
          32'(dec_s[0] + FB * CPB - 1));
    end
    chk("a5_e1_high", 32'(line[L + 1]), 32'd1);
    chk("a5_width",   32'(dec_err), 32'd0);
    chk("a5_done_n",  32'(cnt_from(done_q, L)), 32'd1);

    // Three back-to-back frames
    L = line.size();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_idle("b2b", 800);
    decode(L);
    chk("b2b_frames", 32'(dec_b.size()), 32'd3);
    chk("b2b_width",  32'(dec_err), 32'd0);
    chk("b2b_done_n", 32'(cnt_from(done_q, L)), 32'd3);
    if (dec_b.size() == 3) begin
      chk("b2b_b0", 32'(dec_b[0]), 32'h00);
      chk("b2b_b1", 32'(dec_b[1]), 32'hFF);
      chk("b2b_b2", 32'(dec_b[2]), 32'h3C);
      chk("b2b_gap0", 32'(dec_s[1] - dec_s[0]), 32'(FB * CPB));
      chk("b2b_gap1", 32'(dec_s[2] - dec_s[1]), 32'(FB * CPB));
    end
    s = first_from(done_q, L);
    chk("b2b_done1", 32'(first_from(done_q, s + 1) - s), 32'(FB * CPB));

    // Overflow with transmitter disabled
    tx_enable = 1'b0;
    L = line.size();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      exp_q.push_back(r);
      push(r);
    end
    chk("ovf_full4", 32'(fifo_full), 32'd1);
    push(8'($urandom));
    chk("ovf_pulse", 32'(tx_overflow), 32'd1);
    tick(1);
    chk("ovf_clear", 32'(tx_overflow), 32'd0);
    tick(40);
    chk("ovf_count", 32'(cnt_from(ovf_q, L)), 32'd1);
    chk("ovf_line_high", 32'(zeros_from(L)), 32'd0);
    chk("ovf_busy", 32'(tx_busy), 32'd0);
    tx_enable = 1'b1;
    wait_idle("ovf", 1200);
    decode(L);
    chk("ovf_frames", 32'(dec_b.size()), 32'd4);
    chk("ovf_width",  32'(dec_err), 32'd0);
    for (int k = 0; k < 4 && k < dec_b.size(); k++)
      chk("ovf_byte", 32'(dec_b[k]), 32'(exp_q[k]));

    // Reset during data bit 3
    L = line.size();
    push(8'h55);
    push(8'($urandom));
    s = L + 2;
    n = 0;
    while (line.size() < s + 4 * CPB + 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reach", 32'(n < 500), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_txd",   32'(txd),        32'd1);
    chk("rst_mid_busy",  32'(tx_busy),    32'd0);
    chk("rst_mid_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    L2 = line.size();
    tick(300);
    chk("rst_after_line",  32'(zeros_from(L2)), 32'd0);
    chk("rst_after_empty", 32'(fifo_empty),     32'd1);
    chk("rst_after_busy",  32'(tx_busy),        32'd0);

    // Full FIFO, push and pop together at the STOP->START edge
    tx_enable = 1'b0;
    L = line.size();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      exp_q.push_back(r);
      push(r);
    end
    chk("pp_full", 32'(fifo_full), 32'd1);
    tx_enable = 1'b1;
    @(negedge clk);
    r = 8'($urandom);
    exp_q.push_back(r);
    push(r);
    chk("pp_refull", 32'(fifo_full), 32'd1);
    tick(FB * CPB - 2);
    r = 8'($urandom);
    exp_q.push_back(r);
    push(r);
    chk("pp_done_edge", 32'(tx_done),     32'd1);
    chk("pp_no_ovf",    32'(tx_overflow), 32'd0);
    chk("pp_still_full", 32'(fifo_full),  32'd1);
    wait_idle("pp", 2000);
    decode(L);
    chk("pp_frames", 32'(dec_b.size()), 32'd6);
    chk("pp_width",  32'(dec_err), 32'd0);
    chk("pp_ovf_n",  32'(cnt_from(ovf_q, L)), 32'd0);
    for (int k = 0; k < 6 && k < dec_b.size(); k++)
      chk("pp_byte", 32'(dec_b[k]), 32'(exp_q[k]));

    // Random bursts
    for (int t = 0; t < 6; t++) begin
      nb = $urandom_range(1, 5);
      L = line.size();
      exp_q.delete();
      for (int k = 0; k < nb; k++) begin
        r = 8'($urandom);
        exp_q.push_back(r);
        push(r);
      end
      wait_idle("rnd", nb * 200 + 50);
      decode(L);
      chk("rnd_frames", 32'(dec_b.size()), 32'(nb));
      chk("rnd_width",  32'(dec_err), 32'd0);
      chk("rnd_ovf_n",  32'(cnt_from(ovf_q, L)), 32'd0);
      for (int k = 0; k < nb && k < dec_b.size(); k++)
        chk("rnd_byte", 32'(dec_b[k]), 32'(exp_q[k]));
    end

`ifdef UART_TX_PARITY_EN
    for (int o = 0; o < 2; o++) begin
      tx_parity_odd = 1'(o);
      L = line.size();
      push(8'h07);
      wait_idle("par", 400);
      decode(L);
      chk("par_frames", 32'(dec_b.size()), 32'd1);
      if (dec_b.size() == 1) begin
        chk("par_byte", 32'(dec_b[0]), 32'h07);
        chk("par_bit",  32'(dec_p[0]), 32'(o == 0));
        chk("par_len", 32'(first_from(done_q, L) - dec_s[0] + 1), 32'd176);
      end
    end
    for (int t = 0; t < 4; t++) begin
      tx_parity_odd = 1'($urandom);
      r = 8'($urandom);
      L = line.size();
      push(r);
      wait_idle("parr", 400);
      decode(L);
      chk("parr_frames", 32'(dec_b.size()), 32'd1);
      if (dec_b.size() == 1)
        chk("parr_bit", 32'(dec_p[0]),
            32'(($countones(r) % 2) ^ int'(tx_parity_odd)));
    end
    tx_parity_odd = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit stage of the APB UART. Sits directly downstream of APB_interface and consumes its txStart/txData strobe.
- Buffers bytes in a small FIFO and serialises each one onto txd as an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
- Contains its own baud counter and reports done/busy/full status back to the interface.

Parameters:
- CLOCK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2 and ≥2.
- CLKS_PER_BIT, localparam = CLOCK_RATE/BAUD_RATE (integer division, truncated); must be ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_start  in  1  push strobe; each cycle it is high pushes tx_data.
- tx_data  in  8  byte to push.
- tx_enable  in  1  allows new frames to start.
- txd  out  1  serial line, idle high.
- tx_busy  out  1  high while the FSM is not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- tx_overflow  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (async assert, sync release):
  - txd=1, tx_busy=0, tx_done=0, fifo_full=0, fifo_empty=1, tx_overflow=0.
  - FSM=IDLE, baud counter=0, bit index=0, FIFO pointers and count=0.
  - Reset mid-frame aborts the frame immediately: txd returns high and queued bytes are lost.
- FIFO:
  - Registered circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1.
  - Push when full and no pop in the same cycle: byte is dropped and tx_overflow pulses.
  - Push and pop in the same cycle: both take effect; count is unchanged, including when full.
  - fifo_full and fifo_empty are registered and derived from the next count.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
  - IDLE: txd=1. If fifo_empty=0 and tx_enable=1, pop the head into a shift register and go to START; baud counter=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
  - DATA: txd=shift[0]. Each bit lasts CLKS_PER_BIT cycles; shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the last cycle tx_done=1 for that cycle, then:
    - if fifo_empty=0 and tx_enable=1: pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets to 0 at every bit boundary, so each bit is exactly CLKS_PER_BIT cycles wide.
- txd is driven from a register, so there is no combinational glitching.
- Latency: tx_start sampled on edge E0 (FIFO written, empty→0). FSM pops on E1. txd falls on E2.
- Frame length is 10*CLKS_PER_BIT cycles (11* with parity).
- tx_enable deasserted mid-frame: the current frame completes normally; no new frame starts until tx_enable returns high.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds input tx_parity_odd (1 bit) and a PARITY state between DATA and STOP.
  - PARITY drives the XOR of the 8 data bits (even parity), inverted when tx_parity_odd=1, for CLKS_PER_BIT cycles.
  - tx_parity_odd is sampled at pop time.
- When not defined: no PARITY state and no tx_parity_odd port; frame is 8N1 only.

Test Plan (CLOCK_RATE=160, BAUD_RATE=10 → CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Reset → txd=1, fifo_empty=1, tx_busy=0. Push 0xA5 with tx_enable=1 → txd falls 2 edges later; line reads 0,1,0,1,0,0,1,0,1,1 with each bit 16 cycles wide; tx_done pulses once at cycle 160 of the frame.
- Push 0x00, 0xFF, 0x3C in consecutive cycles → three frames back-to-back with no high gap between stop bit and next start bit; three tx_done pulses spaced 160 cycles apart.
- With tx_enable=0, push 5 bytes → fifo_full=1 after the 4th push; 5th push gives a 1-cycle tx_overflow; txd stays 1.
  - Then set tx_enable=1 → exactly 4 frames are sent.
- Deassert rst_n during DATA bit 3 of 0x55 → txd=1 and tx_busy=0 immediately; after release no frame is sent and fifo_empty=1.
- Full FIFO with push and pop in the same cycle (at the STOP→START transition) → no overflow; fifo_full stays 1; the pushed byte is transmitted last.
- With UART_TX_PARITY_EN: push 0x07 with tx_parity_odd=0 → parity bit=1, frame is 176 cycles; with tx_parity_odd=1 → parity bit=0.
